// File: rtl/udp_pkt_sched.sv
// udp_pkt_sched: launches UDP frames from the AD-sample FIFO, either when a full
// packet is buffered or after a flush timeout with partial data.
`default_nettype none

module udp_pkt_sched #(
    parameter int PKT_BYTES = 1024,
    parameter int CNT_W     = 11,
    parameter int FLUSH_CYC = 125000,
    parameter int DONE_CYC  = 65535,
    parameter int GAP_CYC   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] fifo_rd_cnt,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_dout,
    output logic             fifo_rd_en,
    input  logic             tx_req,
    output logic [7:0]       tx_data,
    output logic             tx_start_en,
    output logic [15:0]      tx_byte_num,
    input  logic             tx_done,
    output logic             busy,
    output logic [31:0]      pkt_cnt,
    output logic             underrun,
    output logic             timeout_err
);

    localparam int FT_W = $clog2(FLUSH_CYC + 1);
    localparam int WD_W = $clog2(DONE_CYC + 1);
    localparam int PH_W = $clog2(GAP_CYC);

    localparam logic [CNT_W-1:0] PKT_C      = CNT_W'(PKT_BYTES);
    localparam logic [FT_W-1:0]  FLUSH_LAST = FT_W'(FLUSH_CYC - 1);
    localparam logic [WD_W-1:0]  DONE_C     = WD_W'(DONE_CYC);
    localparam logic [PH_W-1:0]  START_LAST = PH_W'(3);
    localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [FT_W-1:0]   flush_q, flush_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [15:0]       byte_num_q, byte_num_d;
    logic [31:0]       pkt_q, pkt_d;
    logic              underrun_q;
    logic              tmo;

    // The FIFO's one-cycle read latency lines up with the transmitter's sampling.
    assign fifo_rd_en  = tx_req & ~fifo_empty;
    assign tx_data     = fifo_dout;
    assign tx_start_en = (state_q == S_START);
    assign busy        = (state_q == S_START) || (state_q == S_WAIT_DONE) || (state_q == S_GAP);
    assign tx_byte_num = byte_num_q;
    assign pkt_cnt     = pkt_q;
    assign underrun    = underrun_q;
    assign timeout_err = tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            flush_q    <= '0;
            wd_q       <= '0;
            ph_q       <= '0;
            byte_num_q <= '0;
            pkt_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            wd_q       <= wd_d;
            ph_q       <= ph_d;
            byte_num_q <= byte_num_d;
            pkt_q      <= pkt_d;
            underrun_q <= underrun_q | (tx_req & fifo_empty);
        end
    end

    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        wd_d       = wd_q;
        ph_d       = ph_q;
        byte_num_d = byte_num_q;
        pkt_d      = pkt_q;
        tmo        = 1'b0;
        case (state_q)
            S_IDLE: begin
                flush_d = '0;
                if (enable) state_d = S_ARM;
            end
            S_ARM: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    flush_d = '0;
                end else if (fifo_rd_cnt >= PKT_C) begin
                    byte_num_d = 16'(PKT_BYTES);
                    state_d    = S_START;
                    flush_d    = '0;
                    wd_d       = '0;
                    ph_d       = '0;
                end else if (fifo_rd_cnt != '0) begin
                    if (flush_q == FLUSH_LAST) begin
                        byte_num_d = 16'(fifo_rd_cnt);
                        state_d    = S_START;
                        flush_d    = '0;
                        wd_d       = '0;
                        ph_d       = '0;
                    end else begin
                        flush_d = flush_q + 1'b1;
                    end
                end else begin
                    flush_d = '0;
                end
            end
            S_START: begin
                // Watchdog runs from START entry, so it also ticks here.
                wd_d = wd_q + 1'b1;
                if (ph_q == START_LAST) begin
                    state_d = S_WAIT_DONE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                wd_d = wd_q + 1'b1;
                if (tx_done) begin
                    pkt_d   = pkt_q + 1'b1;
                    state_d = S_GAP;
                    ph_d    = '0;
                end else if (wd_q == DONE_C) begin
                    tmo     = 1'b1;
                    state_d = S_GAP;
                    ph_d    = '0;
                end
            end
            S_GAP: begin
                if (ph_q == GAP_LAST) begin
                    state_d = enable ? S_ARM : S_IDLE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_udp_pkt_sched.sv
// tb_udp_pkt_sched: directed and randomized checks of udp_pkt_sched against a
// packet-level model of launch latency, length, completion count and spacing.
`default_nettype none

module tb_udp_pkt_sched;

    localparam int PKT  = 1024;
    localparam int FLSH = 50;
    localparam int DONE = 200;
    localparam int GAP  = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [10:0] fifo_rd_cnt;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_done;
    logic        busy;
    logic [31:0] pkt_cnt;
    logic        underrun;
    logic        timeout_err;

    udp_pkt_sched #(
        .PKT_BYTES(PKT), .CNT_W(11), .FLUSH_CYC(FLSH), .DONE_CYC(DONE), .GAP_CYC(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_rd_cnt(fifo_rd_cnt),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .tx_req(tx_req), .tx_data(tx_data), .tx_start_en(tx_start_en),
        .tx_byte_num(tx_byte_num), .tx_done(tx_done), .busy(busy), .pkt_cnt(pkt_cnt),
        .underrun(underrun), .timeout_err(timeout_err)
    );

    always #4 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fall_cyc = 0;
    bit have_fall = 1'b0;
    logic [31:0] exp_pkt = 32'd0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_fill(input int v);
        fifo_rd_cnt = 11'(v);
        fifo_empty  = (v == 0);
    endtask

    // Model: from ARM with the timer at zero, a full FIFO launches after one
    // cycle and partial data after FLSH cycles; length is min(fill, PKT).
    function automatic int lat_of(input int f);
        return (f >= PKT) ? 1 : FLSH;
    endfunction

    function automatic int len_of(input int f);
        return (f >= PKT) ? PKT : f;
    endfunction

    // Runs one packet from launch wait to GAP exit; done_dly < 0 means no tx_done.
    task automatic do_packet(input int exp_lat, input int exp_bytes, input int done_dly,
                             input bit drop_en);
        int  n;
        int  hi;
        int  k;
        int  g;
        bit  stable;
        n = 0;
        while (busy !== 1'b1 && n < exp_lat + 200) begin
            tick();
            n++;
        end
        chk("start_latency", n, exp_lat);
        chk("byte_num", {16'd0, tx_byte_num}, exp_bytes);
        if (have_fall) chk("start_low_gap_ok", {31'd0, (cyc - fall_cyc) >= GAP}, 1);
        hi = 0;
        while (tx_start_en === 1'b1 && hi < 10) begin
            tick();
            hi++;
        end
        chk("start_high_len", hi, 4);
        fall_cyc  = cyc;
        have_fall = 1'b1;
        if (drop_en) enable = 1'b0;
        stable = 1'b1;
        if (done_dly >= 0) begin
            repeat (done_dly) begin
                tick();
                if (tx_byte_num !== 16'(exp_bytes)) stable = 1'b0;
            end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            exp_pkt = exp_pkt + 1;
            chk("pkt_cnt_done", pkt_cnt, exp_pkt);
        end else begin
            k = 4;
            while (timeout_err !== 1'b1 && k < DONE + 20) begin
                tick();
                k++;
            end
            chk("watchdog_cycles", k, DONE);
            tick();
            chk("timeout_one_cycle", {31'd0, timeout_err}, 0);
            chk("pkt_cnt_timeout", pkt_cnt, exp_pkt);
        end
        g = 0;
        while (busy === 1'b1 && g < 50) begin
            if (tx_byte_num !== 16'(exp_bytes) || tx_start_en !== 1'b0) stable = 1'b0;
            tick();
            g++;
        end
        chk("gap_cycles", g, GAP);
        chk("byte_num_stable", {31'd0, stable}, 1);
    endtask

    initial begin
        int f;
        int d;
        int n;
        bit idle_ok;
        rst_n = 1'b0; enable = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
        fifo_dout = 8'h00;
        set_fill(0);
        repeat (3) tick();
        chk("rst_start_en", {31'd0, tx_start_en}, 0);
        chk("rst_byte_num", {16'd0, tx_byte_num}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_underrun", {31'd0, underrun}, 0);
        chk("rst_timeout", {31'd0, timeout_err}, 0);
        rst_n = 1'b1;
        tick();

        // Datapath bridge with data present, then a request against an empty FIFO.
        set_fill(200);
        for (int i = 0; i < 5; i++) begin
            tx_req = 1'b1;
            fifo_dout = 8'($urandom);
            #1;
            chk("rd_en_mirror", {31'd0, fifo_rd_en}, 1);
            chk("tx_data_pass", {24'd0, tx_data}, {24'd0, fifo_dout});
            tick();
        end
        tx_req = 1'b0;
        #1;
        chk("rd_en_idle", {31'd0, fifo_rd_en}, 0);
        chk("underrun_clean", {31'd0, underrun}, 0);
        set_fill(0);
        tx_req = 1'b1;
        #1;
        chk("rd_en_empty", {31'd0, fifo_rd_en}, 0);
        tick();
        tx_req = 1'b0;
        chk("underrun_set", {31'd0, underrun}, 1);

        // Full packet launched one cycle after the fill jump.
        enable = 1'b1;
        tick();
        set_fill(1024);
        do_packet(1, 1024, 10, 1'b0);

        // Partial flush, then a flush whose timer restarts after the FIFO drains.
        set_fill(100);
        do_packet(FLSH, 100, 5, 1'b0);
        set_fill(100);
        repeat (30) tick();
        set_fill(0);
        repeat (3) tick();
        set_fill(100);
        do_packet(FLSH, 100, 7, 1'b0);

        // Watchdog expiry.
        set_fill(1024);
        do_packet(1, 1024, -1, 1'b0);

        // Enable dropped mid-packet: completes, then idles despite a full FIFO.
        set_fill(300);
        do_packet(FLSH, 300, 20, 1'b1);
        set_fill(1500);
        idle_ok = 1'b1;
        repeat (5) begin
            tick();
            if (busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("idle_after_disable", {31'd0, idle_ok}, 1);
        enable = 1'b1;
        do_packet(2, 1024, 3, 1'b0);

        // Back-to-back full packets.
        exp_pkt = pkt_cnt === exp_pkt ? exp_pkt : exp_pkt;
        for (int p = 0; p < 3; p++) begin
            set_fill(1024 + $urandom_range(0, 1000));
            do_packet(1, 1024, $urandom_range(0, 60), 1'b0);
        end

        // Randomized fills and completion delays.
        for (int p = 0; p < 5; p++) begin
            f = ($urandom_range(0, 1) == 1) ? $urandom_range(1024, 2047) : $urandom_range(1, 1023);
            d = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 150);
            set_fill(f);
            do_packet(lat_of(f), len_of(f), d, 1'b0);
        end
        chk("underrun_sticky", {31'd0, underrun}, 1);

        // Reset asserted during START.
        set_fill(1024);
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("pre_reset_start", {31'd0, tx_start_en}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_start_en", {31'd0, tx_start_en}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_byte_num", {16'd0, tx_byte_num}, 0);
        chk("mid_rst_pkt_cnt", pkt_cnt, 0);
        chk("mid_rst_underrun", {31'd0, underrun}, 0);
        chk("mid_rst_timeout", {31'd0, timeout_err}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
